// File: rtl/boolean_sweep_gen.sv
// boolean_sweep_gen: drives all eight {a,b,c} input combinations into a
// downstream 3-input boolean block and records its response in a truth table.
// Each combination is held HOLD_CYCLES clocks. The response is sampled on the
// last edge of each hold window. The finished table is compared against a
// golden value.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request a sweep (honoured in IDLE only)
//   abort        synchronous cancel, highest priority after reset
//   d_in         response of the downstream block
//   expected     golden truth table, bit i for index {a,b,c} = i
//   a, b, c      registered drive to the downstream block (a = MSB)
//   busy         sweep in progress
//   done         one-cycle pulse at sweep completion
//   truth_table  captured responses, bit i for index i
//   mismatch     last completed truth_table differed from expected
module boolean_sweep_gen #(
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       d_in,
  input  logic [7:0] expected,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic       mismatch
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] index;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       tt_sampled_c;

  // Truth table as it will look once the current d_in is captured.
  // The final mismatch check uses it so that it includes the index-7 sample.
  always_comb begin
    tt_sampled_c        = truth_table;
    tt_sampled_c[index] = d_in;
  end

  // Sweep controller with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      index       <= '0;
      hold_cnt    <= '0;
      a           <= 1'b0;
      b           <= 1'b0;
      c           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= 8'h00;
      mismatch    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state     <= S_DRIVE;
            index     <= '0;
            hold_cnt  <= '0;
            busy      <= 1'b1;
            {a, b, c} <= 3'b000;
          end
        end

        S_DRIVE: begin
          if (abort) begin
            // Cancel: captured bits stay, mismatch is left untouched
            state     <= S_IDLE;
            index     <= '0;
            hold_cnt  <= '0;
            busy      <= 1'b0;
            {a, b, c} <= 3'b000;
          end else if (hold_cnt == HOLD_LAST) begin
            truth_table[index] <= d_in;
            hold_cnt           <= '0;
            if (index == IDX_LAST) begin
              state     <= S_DONE;
              index     <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              {a, b, c} <= 3'b000;
              mismatch  <= (tt_sampled_c != expected);
            end else begin
              index     <= index + IDX_W'(1);
              {a, b, c} <= index + IDX_W'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          // Single cycle. A start seen here is ignored.
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boolean_sweep_gen.sv
// Self-checking bench for boolean_sweep_gen.
// The bench uses HOLD_CYCLES = 4. The downstream block is modelled either
// as (a&b)|c or as a random 8-entry lookup table.
module tb_boolean_sweep_gen;

  localparam int H = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       d_in;
  logic [7:0] expected;
  logic       a, b, c;
  logic       busy;
  logic       done;
  logic [7:0] truth_table;
  logic       mismatch;

  logic [7:0] func;
  logic       use_formula;
  logic [7:0] tt_model;
  logic       mm_model;

  int checks;
  int errors;

  boolean_sweep_gen #(.HOLD_CYCLES(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .d_in        (d_in),
    .expected    (expected),
    .a           (a),
    .b           (b),
    .c           (c),
    .busy        (busy),
    .done        (done),
    .truth_table (truth_table),
    .mismatch    (mismatch)
  );

  // Downstream boolean block model
  assign d_in = use_formula ? ((a & b) | c) : func[{a, b, c}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_abc"}, 32'({a, b, c}), 32'd0);
  endtask

  // Runs one sweep from IDLE. abort_at = k aborts at the k-th edge after the
  // start edge (0 = no abort). In noisy mode, start and expected change while
  // the sweep runs. Only expected at the completion edge counts.
  task automatic run_sweep(input logic [7:0] f, input bit formula, input int abort_at,
                           input bit noisy, input logic [7:0] exp_final);
    bit aborted;
    func        = f;
    use_formula = formula;
    expected    = exp_final;
    start       = 1'b1;
    tick();
    start   = 1'b0;
    aborted = 1'b0;
    for (int k = 1; k <= 8 * H; k++) begin
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("run_abc", 32'({a, b, c}), 32'((k - 1) / H));
      if (noisy) begin
        start    = 1'($urandom_range(0, 1));
        expected = (k == 8 * H) ? exp_final : 8'($urandom);
      end
      abort = (k == abort_at);
      tick();
      abort = 1'b0;
      start = 1'b0;
      if (k == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    // Sample j happens at edge (j+1)*H after start. An abort on that same edge wins.
    for (int j = 0; j < 8; j++)
      if (!aborted || ((j + 1) * H < abort_at)) tt_model[j] = f[j];
    if (aborted) begin
      check_idle_outputs("abort");
    end else begin
      mm_model = (tt_model != exp_final);
      check("end_done", 32'(done), 32'd1);
      check("end_busy", 32'(busy), 32'd0);
      check("end_abc", 32'({a, b, c}), 32'd0);
      tick();
      check_idle_outputs("post_done");
    end
    check("truth_table", 32'(truth_table), 32'(tt_model));
    check("mismatch", 32'(mismatch), 32'(mm_model));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    expected    = 8'h00;
    func        = 8'h00;
    use_formula = 1'b1;
    tt_model    = 8'h00;
    mm_model    = 1'b0;

    // Reset values, and no sweep after reset release without a start
    #23;
    check_idle_outputs("reset");
    check("reset_tt", 32'(truth_table), 32'h00);
    check("reset_mm", 32'(mismatch), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check_idle_outputs("post_reset");

    // (a&b)|c with a matching golden table, then with a differing one
    run_sweep(8'hEA, 1'b1, 0, 1'b0, 8'hEA);
    check("formula_tt", 32'(truth_table), 32'hEA);
    check("formula_mm", 32'(mismatch), 32'd0);
    run_sweep(8'hEA, 1'b1, 0, 1'b0, 8'hEB);
    check("formula_mm1", 32'(mismatch), 32'd1);
    tick();
    check("formula_mm1_hold", 32'(mismatch), 32'd1);

    // Abort during index 3: bits [2:0] are new, bits [7:3] are kept
    run_sweep(8'h15, 1'b0, 14, 1'b0, 8'h00);
    check("abort_tt", 32'(truth_table), 32'hED);

    // start held high: DONE ignores it, and IDLE after DONE restarts
    func        = 8'hEA;
    use_formula = 1'b1;
    expected    = 8'hEA;
    start       = 1'b1;
    tick();
    for (int k = 1; k <= 8 * H; k++) begin
      check("hold_busy", 32'(busy), 32'd1);
      tick();
    end
    check("hold_done", 32'(done), 32'd1);
    tt_model = 8'hEA;
    mm_model = 1'b0;
    tick();
    check_idle_outputs("hold_done_ignores_start");
    tick();
    check("hold_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("hold_abort");
    check("hold_tt", 32'(truth_table), 32'(tt_model));
    check("hold_mm", 32'(mismatch), 32'(mm_model));

    // start together with abort in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_idle_outputs("start_abort_idle");
    tick();
    check_idle_outputs("start_abort_idle2");

    // Randomized sweeps: random function, golden table, abort point and noise
    for (int it = 0; it < 24; it++) begin
      logic [7:0] f;
      logic [7:0] ex;
      int         ab;
      f  = 8'($urandom);
      ex = ($urandom_range(0, 1) == 0) ? f : 8'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8 * H)) : 0;
      run_sweep(f, 1'b0, ab, 1'b1, ex);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Asynchronous reset in the middle of a clock cycle during index 5
    func        = 8'h5A;
    use_formula = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    repeat (5 * H + 1) tick();
    check("pre_reset_abc", 32'({a, b, c}), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset_tt", 32'(truth_table), 32'h00);
    check("async_reset_mm", 32'(mismatch), 32'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      check("no_done_after_reset", 32'(done), 32'd0);
      check("no_busy_after_reset", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boolean_sweep_gen.md
BOOLEAN_SWEEP_GEN -- requirements
Module: boolean_sweep_gen

Interface
REQ-001 Parameter: HOLD_CYCLES, default 20, clock cycles each input combination is held (legal range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a full 8-combination sweep; sampled on rising edge of clk in IDLE only.
REQ-005 abort  input  1  synchronous sweep cancel; takes priority over all other inputs except rst_n.
REQ-006 d_in  input  1  response of the downstream 3-input boolean block.
REQ-007 expected  input  8  golden truth table; bit i is the expected d for index i = {a,b,c}.
REQ-008 a, b, c  output  1 each  drive to the downstream block's a/b/c inputs, registered.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  single-cycle pulse on sweep completion.
REQ-011 truth_table  output  8  captured responses; bit i holds d_in sampled for index i.
REQ-012 mismatch  output  1  registered; high when the last completed truth_table differs from expected.

Function
REQ-013 FSM states: IDLE, DRIVE, DONE; encoding left to implementer.
REQ-014 IDLE: a=b=c=0, busy=0, done=0; start=1 at an edge -> DRIVE, index=0, hold counter=0.
REQ-015 DRIVE: {a,b,c} = index (a = MSB); busy=1; hold counter increments each cycle from 0.
REQ-016 Sampling: at the edge where the hold counter = HOLD_CYCLES-1, truth_table[index] <= d_in, counter clears, index increments.
REQ-017 Timing: if start is sampled at edge E0, d_in is sampled at edges E0+H, E0+2H, ..., E0+8H (H = HOLD_CYCLES).
REQ-018 After the sample for index 7 (edge E0+8H) -> DONE: done=1, busy=0, a=b=c=0; mismatch <= (final truth_table != expected).
REQ-019 DONE lasts exactly one cycle, then -> IDLE unconditionally; start during DONE is ignored.
REQ-020 start while busy is ignored; no restart or queueing.
REQ-021 index is 3 bits and does not wrap within a sweep; the sweep ends at index 7.
REQ-022 truth_table bits for unsampled indices keep their previous values during a sweep; it is not cleared at start.
REQ-023 expected is compared only at the DONE transition; changes to expected at other times have no effect on mismatch.
REQ-024 abort=1 in DRIVE -> IDLE next edge: a=b=c=0, busy=0, no done pulse; mismatch unchanged; truth_table keeps the bits already captured.
REQ-025 abort=1 together with start in IDLE -> remain in IDLE.
REQ-026 Hold counter width is 8 bits, and it never exceeds HOLD_CYCLES-1.

Reset
REQ-027 rst_n=0 forces immediately, regardless of clk: state IDLE, index 0, counter 0, a=b=c=0, busy=0, done=0, truth_table=8'h00, mismatch=0.
REQ-028 Reset asserted mid-sweep discards the sweep; no done pulse is produced on or after reset release.
REQ-029 After rst_n deasserts, the first sweep starts only on a later start=1.

Verification
REQ-030 H=4, d_in = (a&b)|c, expected=8'hEA, start pulse -> done pulses at E0+8H+1 cycle, truth_table=8'hEA, mismatch=0.
REQ-031 Same as REQ-030 with expected=8'hEB -> truth_table=8'hEA, mismatch=1 in the cycle after done.
REQ-032 Sequence check: {a,b,c} steps through 000..111, each value held exactly 4 cycles; busy=1 for exactly 32 cycles.
REQ-033 start held high for the whole sweep -> exactly one sweep and one done pulse; a second sweep begins only if start is still high in IDLE after DONE.
REQ-034 abort asserted at index 3 -> next cycle IDLE, a=b=c=0, no done pulse, truth_table[2:0] updated, bits [7:3] unchanged.
REQ-035 rst_n pulsed low mid-cycle during index 5 -> outputs are at their reset values before the next clk edge, and no done pulse follows.
